// File: rtl/dma_copy.sv
// dma_copy: MMIO-configured memory-to-memory word copy engine and bus initiator.
// Define DMA_COPY_TIMEOUT_EN to abandon bus requests stalled for TIMEOUT_CYCLES.
module dma_copy #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        dma_busy
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP} state_t;
  state_t state, nstate;
  logic [31:0] src, dst, src_ptr, dst_ptr, rd_mux;
  logic [LEN_WIDTH-1:0] len, count;
  logic done, error, abort_q, tmo, idle, ctrl, start, abort, xfer, finished;
  assign idle = state == IDLE;
  assign ctrl = cs && we && address == 8'h08;
  assign start = ctrl && write_data[0] && idle;
  assign abort = ctrl && write_data[1] && !idle;
  assign xfer = mem_valid && mem_ready;
  assign dma_busy = !idle;
  assign finished = state == WR_GAP && count == '0;
`ifdef DMA_COPY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) tcnt <= '0;
    else tcnt <= !mem_valid || mem_ready ? '0 : tcnt + 1'b1;
  assign tmo = mem_valid && !mem_ready && tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = start && len != '0 ? RD_REQ : IDLE;
      RD_REQ:  nstate = tmo ? IDLE : xfer ? RD_GAP : RD_REQ;
      RD_GAP:  nstate = abort || abort_q ? IDLE : WR_REQ;
      WR_REQ:  nstate = tmo ? IDLE : xfer ? WR_GAP : WR_REQ;
      WR_GAP:  nstate = finished || abort || abort_q ? IDLE : RD_REQ;
      default: nstate = IDLE;
    endcase
  end
  // Bus outputs are registered from the next state so they are stable for the whole request
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      mem_valid <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      src_ptr <= '0;
      dst_ptr <= '0;
      count <= '0;
      done <= 1'b0;
      error <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state <= nstate;
      mem_valid <= nstate == RD_REQ || nstate == WR_REQ;
      mem_wstrb <= nstate == WR_REQ ? 4'hF : 4'h0;
      mem_addr <= nstate == RD_REQ ? (idle ? src : src_ptr) : nstate == WR_REQ ? dst_ptr : 32'h0;
      if (state == RD_REQ && xfer) mem_wdata <= mem_rdata;
      abort_q <= nstate != IDLE && (abort_q || abort);
      if (start) begin
        src_ptr <= src;
        dst_ptr <= dst;
        count <= len;
        done <= len == '0;
        error <= 1'b0;
      end else begin
        if (state == WR_REQ && xfer) begin
          src_ptr <= src_ptr + 32'd4;
          dst_ptr <= dst_ptr + 32'd4;
          count <= count - 1'b1;
        end
        if (!idle && nstate == IDLE) begin
          done <= finished;
          error <= !finished;
        end
      end
    end
  always_comb
    rd_mux = address == 8'h09 ? {29'b0, error, done, dma_busy} :
             address == 8'h10 ? src :
             address == 8'h11 ? dst :
             address == 8'h12 ? 32'(len) :
             address == 8'h13 ? 32'(count) : 32'h0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ready <= 1'b0;
      read_data <= '0;
      src <= '0;
      dst <= '0;
      len <= '0;
    end else begin
      ready <= cs;
      read_data <= cs && !we ? rd_mux : 32'h0;
      if (cs && we && idle && address == 8'h10) src <= {write_data[31:2], 2'b00};
      if (cs && we && idle && address == 8'h11) dst <= {write_data[31:2], 2'b00};
      if (cs && we && idle && address == 8'h12) len <= write_data[LEN_WIDTH-1:0];
    end
endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: directed register vectors plus hand-written copy, abort, wrap and stall sequences.
module tb_dma_copy;
  logic clk = 0, reset = 1, cs = 0, we = 0, mem_ready = 0;
  logic [7:0] address = 0;
  logic [31:0] write_data = 0, mem_rdata = 0;
  logic [31:0] read_data, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic ready, mem_valid, dma_busy;

  always #5 clk = ~clk;

  dma_copy dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dma_busy(dma_busy)
  );

  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} txn_t;
  typedef struct {logic w; logic [7:0] a; logic [31:0] d; logic [31:0] exp;} vec_t;
  txn_t log_q[$];
  vec_t vt[11];
  int checks = 0, passed = 0, lat = 2, wcnt = 0, gapcnt = 0, gap_bad = 0, unstable = 0;
  bit hang = 0, first = 1, busy_seen = 0, valid_seen = 0, prev_valid = 0;
  logic [31:0] pa, pd;
  logic [3:0] pw;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[7:0], 24'h0};
  endfunction

  // Bus monitor and responder with programmable latency
  always @(negedge clk) begin
    busy_seen = busy_seen | dma_busy;
    valid_seen = valid_seen | mem_valid;
    if (mem_valid) begin
      if (prev_valid && (mem_addr !== pa || mem_wdata !== pd || mem_wstrb !== pw)) unstable++;
      if (!prev_valid && !first && gapcnt != 1) gap_bad++;
      first = 0;
      gapcnt = 0;
    end else if (dma_busy) gapcnt++;
    prev_valid = mem_valid; pa = mem_addr; pd = mem_wdata; pw = mem_wstrb;
    if (mem_ready) mem_ready = 0;
    else if (mem_valid && !hang) begin
      if (wcnt >= lat - 1) begin
        mem_ready = 1;
        wcnt = 0;
        mem_rdata = mem_word(mem_addr);
        log_q.push_back('{mem_addr, mem_wstrb == 4'h0 ? mem_word(mem_addr) : mem_wdata, mem_wstrb});
      end else wcnt++;
    end else wcnt = 0;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic mmio_wr(logic [7:0] a, logic [31:0] d);
    cs = 1; we = 1; address = a; write_data = d;
    @(negedge clk);
    cs = 0; we = 0;
  endtask

  task automatic mmio_rd(logic [7:0] a, output logic [31:0] d);
    cs = 1; we = 0; address = a;
    @(negedge clk);
    cs = 0;
    d = read_data;
    chk("ready", {31'b0, ready}, 1);
  endtask

  task automatic rd_chk(string name, logic [7:0] a, logic [31:0] exp);
    logic [31:0] d;
    mmio_rd(a, d);
    chk(name, d, exp);
  endtask

  task automatic start_dma();
    first = 1;
    log_q.delete();
    mmio_wr(8'h08, 32'h1);
  endtask

  task automatic wait_idle(int max);
    for (int i = 0; i < max && dma_busy; i++) @(negedge clk);
    chk("wait_idle", {31'b0, dma_busy}, 0);
  endtask

  initial begin
    logic [31:0] d;
    vt[0]  = '{1'b0, 8'h09, 32'h0, 32'h0};
    vt[1]  = '{1'b0, 8'h13, 32'h0, 32'h0};
    vt[2]  = '{1'b1, 8'h10, 32'h4000_0003, 32'h0};
    vt[3]  = '{1'b0, 8'h10, 32'h0, 32'h4000_0000};
    vt[4]  = '{1'b1, 8'h11, 32'h4000_0102, 32'h0};
    vt[5]  = '{1'b0, 8'h11, 32'h0, 32'h4000_0100};
    vt[6]  = '{1'b1, 8'h12, 32'h0001_2345, 32'h0};
    vt[7]  = '{1'b0, 8'h12, 32'h0, 32'h0000_2345};
    vt[8]  = '{1'b0, 8'h55, 32'h0, 32'h0};
    vt[9]  = '{1'b1, 8'h12, 32'h3, 32'h0};
    vt[10] = '{1'b0, 8'h12, 32'h0, 32'h3};
    repeat (3) @(negedge clk);
    chk("reset_ctl", {28'b0, mem_valid, dma_busy, ready, |mem_wstrb}, 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_rdata", read_data, 0);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 11; i++)
      if (vt[i].w) mmio_wr(vt[i].a, vt[i].d);
      else begin
        mmio_rd(vt[i].a, d);
        chk($sformatf("vec%0d", i), d, vt[i].exp);
      end

    // Three-word copy, latency 2
    lat = 2;
    start_dma();
    chk("busy_after_start", {31'b0, dma_busy}, 1);
    wait_idle(200);
    chk("copy_len", log_q.size(), 6);
    for (int k = 0; k < 3 && log_q.size() == 6; k++) begin
      chk($sformatf("rd%0d_addr", k), log_q[2*k].addr, 32'h4000_0000 + 4*k);
      chk($sformatf("rd%0d_strb", k), {28'b0, log_q[2*k].strb}, 0);
      chk($sformatf("wr%0d_addr", k), log_q[2*k+1].addr, 32'h4000_0100 + 4*k);
      chk($sformatf("wr%0d_strb", k), {28'b0, log_q[2*k+1].strb}, 32'hF);
      chk($sformatf("wr%0d_data", k), log_q[2*k+1].data, mem_word(32'h4000_0000 + 4*k));
    end
    chk("gaps", gap_bad, 0);
    chk("stable", unstable, 0);
    rd_chk("copy_status", 8'h09, 32'h2);
    rd_chk("copy_count", 8'h13, 32'h0);
    rd_chk("copy_src", 8'h10, 32'h4000_0000);

    // Abort during second write, latency 4
    mmio_wr(8'h12, 32'd5);
    lat = 4;
    start_dma();
    for (int i = 0; i < 100 && log_q.size() < 3; i++) @(negedge clk);
    for (int i = 0; i < 100 && !(mem_valid && mem_wstrb == 4'hF); i++) @(negedge clk);
    chk("abort_in_wreq", {27'b0, mem_valid, mem_wstrb}, 32'h1F);
    mmio_wr(8'h08, 32'h2);
    wait_idle(100);
    repeat (5) @(negedge clk);
    chk("abort_txns", log_q.size(), 4);
    if (log_q.size() >= 4) chk("abort_last_addr", log_q[3].addr, 32'h4000_0104);
    rd_chk("abort_status", 8'h09, 32'h4);
    rd_chk("abort_count", 8'h13, 32'h3);

    // Zero length: done without touching the bus
    mmio_wr(8'h12, 32'd0);
    busy_seen = 0; valid_seen = 0;
    start_dma();
    repeat (3) @(negedge clk);
    chk("len0_busy", {31'b0, busy_seen}, 0);
    chk("len0_valid", {31'b0, valid_seen}, 0);
    rd_chk("len0_status", 8'h09, 32'h2);

    // Source pointer wraps past 2^32
    mmio_wr(8'h10, 32'hFFFF_FFFC);
    mmio_wr(8'h11, 32'h4000_0200);
    mmio_wr(8'h12, 32'd2);
    lat = 1;
    start_dma();
    wait_idle(100);
    chk("wrap_txns", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("wrap_rd2_addr", log_q[2].addr, 32'h0);
      chk("wrap_wr2_addr", log_q[3].addr, 32'h4000_0204);
      chk("wrap_wr2_data", log_q[3].data, mem_word(32'h0));
    end
    rd_chk("wrap_src", 8'h10, 32'hFFFF_FFFC);
    rd_chk("wrap_status", 8'h09, 32'h2);

    // Register writes and restart ignored while busy
    mmio_wr(8'h10, 32'h4000_0000);
    mmio_wr(8'h12, 32'd3);
    lat = 4;
    start_dma();
    mmio_wr(8'h10, 32'h1234_5678);
    mmio_wr(8'h08, 32'h1);
    wait_idle(200);
    repeat (10) @(negedge clk);
    chk("busy_no_restart", {31'b0, dma_busy}, 0);
    chk("busy_txns", log_q.size(), 6);
    rd_chk("busy_src", 8'h10, 32'h4000_0000);
    rd_chk("busy_status", 8'h09, 32'h2);

    // Responder never answers
    hang = 1;
    mmio_wr(8'h12, 32'd1);
    start_dma();
`ifdef DMA_COPY_TIMEOUT_EN
    repeat (1000) @(negedge clk);
    chk("tmo_hold", {31'b0, mem_valid}, 1);
    repeat (100) @(negedge clk);
    chk("tmo_drop", {31'b0, mem_valid}, 0);
    rd_chk("tmo_status", 8'h09, 32'h4);
    start_dma();
    repeat (50) @(negedge clk);
`else
    repeat (5000) @(negedge clk);
    chk("stall_valid", {31'b0, mem_valid}, 1);
    chk("stall_busy", {31'b0, dma_busy}, 1);
`endif
    reset = 1;
    #1;
    chk("rst_ctl", {28'b0, mem_valid, dma_busy, ready, |mem_wstrb}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    reset = 0;
    hang = 0;
    @(negedge clk);
    rd_chk("rst_status", 8'h09, 32'h0);
    rd_chk("rst_src", 8'h10, 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
